// File: rtl/fp16_add_arbiter.sv
// fp16_add_arbiter: shares one pipelined add_fp16 unit among NUM_REQ requesters.
//
// Requesters hand over operand pairs with valid/ready. A round-robin arbiter grants at most one
// requester per cycle. The granted pair is registered onto add_a/add_b together with a one-cycle
// add_start strobe. A tag pipeline follows each operation through the adder's fixed latency, and
// the result is written into the originator's one-entry response buffer.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   req_valid/ready    per-requester request handshake (req_ready is one-hot or zero)
//   req_a, req_b       per-requester FP16 operands, packed NUM_REQ x 16
//   resp_valid/ready   per-requester response handshake
//   resp_data          per-requester FP16 result, packed NUM_REQ x 16
//   add_start          issue strobe to add_fp16
//   add_a, add_b       operands to add_fp16
//   add_out            result from add_fp16, valid ADD_LATENCY cycles after add_start
//   idle               nothing in flight and no response buffered
module fp16_add_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned ADD_LATENCY = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*16-1:0]  req_a,
    input  logic [NUM_REQ*16-1:0]  req_b,
    output logic [NUM_REQ-1:0]     resp_valid,
    input  logic [NUM_REQ-1:0]     resp_ready,
    output logic [NUM_REQ*16-1:0]  resp_data,
    output logic                   add_start,
    output logic [15:0]            add_a,
    output logic [15:0]            add_b,
    input  logic [15:0]            add_out,
    output logic                   idle
);

    localparam int unsigned IdW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IdW-1:0]        rr_ptr_q;
    logic [NUM_REQ-1:0]    busy_q;
    logic [NUM_REQ-1:0]    resp_valid_q;
    logic [NUM_REQ*16-1:0] resp_data_q;
    logic                  add_start_q;
    logic [15:0]           add_a_q;
    logic [15:0]           add_b_q;
    logic [IdW-1:0]        issue_id_q;
    logic [ADD_LATENCY-1:0] tag_valid_q;
    logic [IdW-1:0]        tag_id_q [ADD_LATENCY];

    logic [NUM_REQ-1:0]    eligible;
    logic                  grant_valid;
    logic [IdW-1:0]        grant_id;
    logic [IdW-1:0]        rr_ptr_next;
    logic [15:0]           grant_a;
    logic [15:0]           grant_b;
    logic [NUM_REQ-1:0]    resp_hs;
    logic                  wb_valid;
    logic [IdW-1:0]        wb_id;

    // Holding eligibility low during reset keeps req_ready at zero while rst is high.
    assign eligible = req_valid & ~busy_q & {NUM_REQ{~rst}};

    // Round-robin search starting at rr_ptr; the first eligible requester wins.
    always_comb begin
        int unsigned idx;
        grant_valid = 1'b0;
        grant_id    = '0;
        rr_ptr_next = rr_ptr_q;
        grant_a     = '0;
        grant_b     = '0;
        idx         = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!grant_valid && eligible[idx]) begin
                grant_valid = 1'b1;
                grant_id    = IdW'(idx);
                rr_ptr_next = IdW'((idx + 1) % NUM_REQ);
                grant_a     = req_a[idx*16 +: 16];
                grant_b     = req_b[idx*16 +: 16];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_valid) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign resp_hs  = resp_valid_q & resp_ready;
    assign wb_valid = tag_valid_q[ADD_LATENCY-1];
    assign wb_id    = tag_id_q[ADD_LATENCY-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q     <= '0;
            busy_q       <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            add_start_q  <= 1'b0;
            add_a_q      <= '0;
            add_b_q      <= '0;
            issue_id_q   <= '0;
            tag_valid_q  <= '0;
            for (int unsigned i = 0; i < ADD_LATENCY; i++) begin
                tag_id_q[i] <= '0;
            end
        end else begin
            // Issue stage: operands hold their last value when nothing is granted.
            add_start_q <= grant_valid;
            if (grant_valid) begin
                rr_ptr_q   <= rr_ptr_next;
                add_a_q    <= grant_a;
                add_b_q    <= grant_b;
                issue_id_q <= grant_id;
            end

            // Tag pipeline is loaded every cycle so back-to-back issues are tracked.
            tag_valid_q[0] <= add_start_q;
            tag_id_q[0]    <= issue_id_q;
            for (int unsigned i = 1; i < ADD_LATENCY; i++) begin
                tag_valid_q[i] <= tag_valid_q[i-1];
                tag_id_q[i]    <= tag_id_q[i-1];
            end

            // A grant needs busy low and a handshake needs busy high, so the two never collide
            // on the same requester; likewise writeback never targets a buffer being drained.
            busy_q <= (busy_q | req_ready) & ~resp_hs;

            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (resp_hs[i]) begin
                    resp_valid_q[i] <= 1'b0;
                end
                if (wb_valid && (wb_id == IdW'(i))) begin
                    resp_valid_q[i]           <= 1'b1;
                    resp_data_q[i*16 +: 16]   <= add_out;
                end
            end
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign add_start  = add_start_q;
    assign add_a      = add_a_q;
    assign add_b      = add_b_q;
    assign idle       = ~(|tag_valid_q) & ~(|resp_valid_q) & ~add_start_q;

endmodule
